// File: rtl/adder_result_accum_if.sv
// Beat-in / total-out handshake bundle for the adder result accumulator.
// The slave side is the accumulator; the master side is whoever feeds and drains it.
interface adder_result_accum_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_sum;
    logic              in_carry;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_total;
    logic              out_ovf;
    logic              busy;

    modport slave (
        input  start, len, in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_total, out_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_total, out_ovf, busy
    );
endinterface

// File: rtl/adder_result_accum.sv
// Accumulates a programmed number of {carry,sum} adder beats into a saturating total
// and holds that total on an output handshake until the consumer takes it.
module adder_result_accum #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_accum_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_rem;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_beat_fire;
    logic [ACC_W-1:0] w_beat_ext;
    logic [ACC_W:0]   w_sum;

    assign w_beat_fire = (r_state == S_ACCUM) && bus.in_valid;
    assign w_beat_ext  = ACC_W'({bus.in_carry, bus.in_sum});
    // One extra bit catches the wrap so saturation is a single MSB test.
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_beat_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_rem   <= bus.len;
                        r_state <= (bus.len != '0) ? S_ACCUM : S_DONE;
                    end
                end
                S_ACCUM: begin
                    if (w_beat_fire) begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (w_sum[ACC_W]) begin
                            r_acc <= '1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        if (r_rem == CNT_W'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_total = r_acc;
    assign bus.out_ovf   = r_ovf;
endmodule
